// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, bit shifting
// on device clock falls, ACK check and bounded timeouts.
module ps2_host_tx #(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned BIT_TIMEOUT_US   = 2000,
  parameter int unsigned FILTER_LEN       = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] tx_status
);

  localparam longint unsigned INHIBIT_CYC =
    (64'(CLK_HZ) * INHIBIT_US + 64'd999_999) / 64'd1_000_000;
  localparam longint unsigned START_CYC = 64'(CLK_HZ) * START_TIMEOUT_US / 64'd1_000_000;
  localparam longint unsigned BIT_CYC   = 64'(CLK_HZ) * BIT_TIMEOUT_US / 64'd1_000_000;

  localparam int unsigned TW = $clog2(START_CYC) + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_CYC - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // Bit 1 = PS/2 clock, bit 0 = PS/2 data.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;
  logic          nack_q, nack_d;

  logic fall;
  logic timer_zero;

  always_comb begin
    sync1_d = {ps2_clk_i, ps2_data_i};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fcnt_d  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_MAX) filt_d[i] = sync2_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  assign fall       = filt_q[1] & ~filt_d[1];
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    status_d  = status_q;
    nack_d    = nack_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          timer_d   = INH_LOAD;
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LOAD == '0);
          nack_d    = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // Start bit is raised one cycle early so it overlaps the last inhibit cycle.
        if (timer_zero) begin
          clk_oe_d = 1'b0;
          state_d  = S_RTS;
        end else begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) data_oe_d = 1'b1;
        end
      end
      S_RTS: begin
        timer_d  = START_LOAD;
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT, S_ACK, S_WAIT_IDLE: begin
        if (timer_zero) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          status_d  = ST_TIMEOUT;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
          if (state_q == S_SHIFT && fall) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[9:1]};
            bitcnt_d  = bitcnt_q + 4'd1;
            timer_d   = BIT_LOAD;
            if (bitcnt_q == 4'd9) state_d = S_ACK;
          end else if (state_q == S_ACK && fall) begin
            nack_d  = filt_q[0];
            timer_d = BIT_LOAD;
            state_d = S_WAIT_IDLE;
          end else if (state_q == S_WAIT_IDLE && filt_q[1] && filt_q[0]) begin
            done_d   = 1'b1;
            status_d = nack_q ? 2'b01 : ST_OK;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      filt_q    <= '1;
      fcnt_q    <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      nack_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      status_q  <= status_d;
      nack_q    <= nack_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_status   = status_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the outbound counterpart of the keyboard receiver inside pyldin2012. It sends command bytes to the keyboard over esp32_ps2clk/esp32_ps2data, e.g. 0xED followed by an LED byte driven from led_capslock/led_latkir. It owns the open-drain clock-inhibit, request-to-send, bit shifting, parity and ACK check, and reports the result to the command sequencer. While busy it signals the receiver to ignore bus activity.

Parameters:
CLK_HZ, 50000000, frequency of clock in Hz (100 MHz PLL divided by 2).
INHIBIT_US, 120, time ps2 clock is held low before the start bit.
START_TIMEOUT_US, 15000, maximum wait for the device's first falling clock edge.
BIT_TIMEOUT_US, 2000, maximum gap between consecutive device falling edges.
FILTER_LEN, 8, cycles a synchronized line must be stable before its filtered value changes.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
ps2_clk_i  in  1  raw PS/2 clock pin level (asynchronous).
ps2_data_i  in  1  raw PS/2 data pin level (asynchronous).
ps2_clk_oe  out  1  1 = pull the PS/2 clock low; 0 = release.
ps2_data_oe  out  1  1 = pull the PS/2 data low; 0 = release.
tx_valid  in  1  request to send tx_data; accepted only when tx_ready=1.
tx_data  in  8  byte to send.
tx_ready  out  1  1 in IDLE only.
tx_busy  out  1  ~tx_ready; the receiver ignores frames while this is 1.
tx_done  out  1  one-cycle pulse when a transfer ends.
tx_status  out  2  valid while tx_done=1 and held until the next accept: 00 ACK ok, 01 NACK (no ACK), 10 timeout.

Behaviour:
- Input conditioning
  - Each line passes a 2-FF synchronizer, then the FILTER_LEN stability filter.
  - Filtered values reset to 1.
  - fall = filtered clock goes 1 -> 0.
- Reset values
  - ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_status=00, state IDLE.
  - A reset mid-transfer releases both lines on the following clock edge and sends no tx_done.
- Accept
  - A transfer is accepted when tx_valid && tx_ready in IDLE.
  - On accept: latch tx_data; compute parity = ~^tx_data (odd parity); build shift = {1 stop, parity, data[7:0]}, sent LSB first.
  - Go to INHIBIT.
- INHIBIT
  - ps2_clk_oe=1 for ceil(CLK_HZ*INHIBIT_US/1e6) cycles.
  - On the last cycle assert ps2_data_oe=1 (start bit).
  - Go to RTS.
- RTS
  - ps2_clk_oe=0, ps2_data_oe stays 1.
  - Timer is loaded with the START timeout; bit counter = 0. Go to SHIFT.
- SHIFT
  - On each fall: ps2_data_oe <= ~shift[0]; shift right; bit counter++; reload the timer with the BIT timeout.
  - Falls 1..8 send data bits D0..D7, fall 9 sends parity, fall 10 sends stop (data released).
  - After fall 10, go to ACK.
- ACK
  - At fall 11, sample filtered data: 0 = ACK (status 00), 1 = NACK (status 01).
  - Go to WAIT_IDLE.
- WAIT_IDLE
  - Wait until filtered clock and data are both 1, bounded by the BIT timeout.
  - Then pulse tx_done and return to IDLE; tx_ready=1 in the next cycle.
- Timeout
  - Timer expiry in RTS/SHIFT/ACK/WAIT_IDLE releases both lines, pulses tx_done with status 10 and returns to IDLE.
  - Timeout takes priority over a fall occurring in the same cycle.
- Timer
  - Down-counter, width clog2(CLK_HZ*START_TIMEOUT_US/1e6)+1.
  - Expiry when it reaches 0 while armed.
- Other rules
  - Device edges in IDLE or INHIBIT are ignored.
  - tx_valid while busy is ignored and not queued.
  - ps2_data_oe changes only in INHIBIT end, on a fall, or on release.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs -> ps2_clk_oe low for ≥6000 cycles; device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done with status 00.
- Send 0x01, then 0x00, then 0xFF -> parity bits 0, 1, 1 respectively; each transfer gets exactly one tx_done pulse with status 00.
- Device clocks all 11 edges but leaves data high at the ACK edge -> tx_status 01; both oe=0; tx_ready returns to 1.
- Device never clocks after RTS -> tx_done at 750000±2 cycles after clock release with status 10; lines released.
- Device stops after 4 falls -> status 10 after 100000 cycles; tx_valid pulsed mid-transfer is ignored (only one tx_done).
- Assert rst during SHIFT -> ps2_clk_oe=ps2_data_oe=0 and tx_ready=1 the next cycle; no tx_done; a new 0xF4 transfer then completes with status 00.
